// File: rtl/mem_stage.sv
// LC-3b MEM stage: word/byte/indirect data-memory access over a ready handshake, feeding the SR latch.
// Optional macro MEM_UNALIGNED_TRAP_EN drops word accesses at odd addresses instead of aligning them.
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_v,
    input  logic [15:0] mem_ir,
    input  logic [15:0] mem_npc,
    input  logic [15:0] mem_address,
    input  logic [15:0] mem_alu_result,
    input  logic [15:0] mem_st_data,
    input  logic [2:0]  mem_drid,
    input  logic [7:0]  mem_cs,
    output logic        mem_stall,
    output logic        mem_unaligned,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    output logic [1:0]  dmem_wmask,
    input  logic [15:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic        sr_v,
    output logic [15:0] sr_ir,
    output logic [15:0] sr_npc,
    output logic [15:0] sr_address,
    output logic [15:0] sr_alu_result,
    output logic [15:0] sr_data,
    output logic [2:0]  sr_drid,
    output logic [3:0]  sr_cs
);

    // Handshake: an access is transferred in any cycle where dmem_req and dmem_ready are both high;
    // until then every dmem_* output is held stable and upstream is stalled.

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT1 = 2'd1;
    localparam logic [1:0] S_ACC2  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [15:0] ptr_q, ptr_d;

    logic        sr_v_q, sr_v_d;
    logic [15:0] sr_ir_q, sr_ir_d;
    logic [15:0] sr_npc_q, sr_npc_d;
    logic [15:0] sr_address_q, sr_address_d;
    logic [15:0] sr_alu_result_q, sr_alu_result_d;
    logic [15:0] sr_data_q, sr_data_d;
    logic [2:0]  sr_drid_q, sr_drid_d;
    logic [3:0]  sr_cs_q, sr_cs_d;

    logic        cs_rd, cs_wr, cs_byte, cs_ind;
    logic        mem_op, in_acc2, in_wait1;
    logic        access_act, final_acc, byte_acc, word_acc;
    logic [15:0] acc_addr;
    logic        acc_we;
    logic        trap;
    logic        req_raw, done_raw, stall_raw;
    logic [7:0]  byte_sel;
    logic [15:0] load_data;

    assign cs_rd   = mem_cs[4];
    assign cs_wr   = mem_cs[5];
    assign cs_byte = mem_cs[6];
    assign cs_ind  = mem_cs[7];

    assign mem_op   = mem_v & (cs_rd | cs_wr);
    assign in_acc2  = (state_q == S_ACC2);
    assign in_wait1 = (state_q == S_WAIT1);

    // WAIT1 and ACC2 only exist for an op in flight, so they always request.
    assign access_act = in_acc2 | in_wait1 | mem_op;
    assign final_acc  = in_acc2 | ~cs_ind;
    assign byte_acc   = cs_byte & ~cs_ind;
    assign word_acc   = ~byte_acc;
    assign acc_addr   = in_acc2 ? ptr_q : mem_address;
    assign acc_we     = cs_wr & final_acc;

`ifdef MEM_UNALIGNED_TRAP_EN
    assign trap      = access_act & word_acc & acc_addr[0];
    assign dmem_addr = acc_addr;
`else
    assign trap      = 1'b0;
    assign dmem_addr = word_acc ? {acc_addr[15:1], 1'b0} : acc_addr;
`endif

    assign req_raw   = access_act & ~trap;
    assign done_raw  = req_raw & dmem_ready & final_acc;
    assign stall_raw = access_act & ~done_raw & ~trap;

    assign dmem_req      = req_raw & ~reset;
    assign dmem_we       = req_raw & acc_we & ~reset;
    assign mem_stall     = stall_raw & ~reset;
    assign mem_unaligned = trap & ~reset;

    assign dmem_wmask = byte_acc ? (acc_addr[0] ? 2'b10 : 2'b01) : 2'b11;
    assign dmem_wdata = byte_acc ? {mem_st_data[7:0], mem_st_data[7:0]} : mem_st_data;

    assign byte_sel  = acc_addr[0] ? dmem_rdata[15:8] : dmem_rdata[7:0];
    assign load_data = byte_acc ? {{8{byte_sel[7]}}, byte_sel} : dmem_rdata;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            S_IDLE, S_WAIT1: begin
                if (trap || !access_act) begin
                    state_d = S_IDLE;
                end else if (!dmem_ready) begin
                    state_d = S_WAIT1;
                end else if (cs_ind) begin
                    state_d = S_ACC2;
                    ptr_d   = dmem_rdata;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACC2: begin
                if (trap || dmem_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        sr_v_d          = sr_v_q;
        sr_ir_d         = sr_ir_q;
        sr_npc_d        = sr_npc_q;
        sr_address_d    = sr_address_q;
        sr_alu_result_d = sr_alu_result_q;
        sr_data_d       = sr_data_q;
        sr_drid_d       = sr_drid_q;
        sr_cs_d         = sr_cs_q;
        // A stalled or trapped instruction leaves a bubble; the other fields keep their last value.
        if (stall_raw || trap) begin
            sr_v_d = 1'b0;
        end else begin
            sr_v_d          = mem_v;
            sr_ir_d         = mem_ir;
            sr_npc_d        = mem_npc;
            sr_address_d    = mem_address;
            sr_alu_result_d = mem_alu_result;
            sr_data_d       = (mem_op && !cs_wr) ? load_data : 16'h0000;
            sr_drid_d       = mem_drid;
            sr_cs_d         = mem_cs[3:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            ptr_q           <= 16'h0000;
            sr_v_q          <= 1'b0;
            sr_ir_q         <= 16'h0000;
            sr_npc_q        <= 16'h0000;
            sr_address_q    <= 16'h0000;
            sr_alu_result_q <= 16'h0000;
            sr_data_q       <= 16'h0000;
            sr_drid_q       <= 3'd0;
            sr_cs_q         <= 4'd0;
        end else begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            sr_v_q          <= sr_v_d;
            sr_ir_q         <= sr_ir_d;
            sr_npc_q        <= sr_npc_d;
            sr_address_q    <= sr_address_d;
            sr_alu_result_q <= sr_alu_result_d;
            sr_data_q       <= sr_data_d;
            sr_drid_q       <= sr_drid_d;
            sr_cs_q         <= sr_cs_d;
        end
    end

    assign sr_v          = sr_v_q;
    assign sr_ir         = sr_ir_q;
    assign sr_npc        = sr_npc_q;
    assign sr_address    = sr_address_q;
    assign sr_alu_result = sr_alu_result_q;
    assign sr_data       = sr_data_q;
    assign sr_drid       = sr_drid_q;
    assign sr_cs         = sr_cs_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: each step drives inputs just after a rising edge,
// checks combinational outputs mid-cycle and the SR latch just after the next edge.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_v;
    logic [15:0] mem_ir, mem_npc, mem_address, mem_alu_result, mem_st_data;
    logic [2:0]  mem_drid;
    logic [7:0]  mem_cs;
    logic        mem_stall, mem_unaligned;
    logic        dmem_req, dmem_we;
    logic [15:0] dmem_addr, dmem_wdata;
    logic [1:0]  dmem_wmask;
    logic [15:0] dmem_rdata;
    logic        dmem_ready;
    logic        sr_v;
    logic [15:0] sr_ir, sr_npc, sr_address, sr_alu_result, sr_data;
    logic [2:0]  sr_drid;
    logic [3:0]  sr_cs;

    int checks = 0;
    int errors = 0;
    int stall_cnt;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .reset(reset), .mem_v(mem_v), .mem_ir(mem_ir), .mem_npc(mem_npc),
        .mem_address(mem_address), .mem_alu_result(mem_alu_result), .mem_st_data(mem_st_data),
        .mem_drid(mem_drid), .mem_cs(mem_cs), .mem_stall(mem_stall), .mem_unaligned(mem_unaligned),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_wmask(dmem_wmask), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .sr_v(sr_v), .sr_ir(sr_ir), .sr_npc(sr_npc), .sr_address(sr_address),
        .sr_alu_result(sr_alu_result), .sr_data(sr_data), .sr_drid(sr_drid), .sr_cs(sr_cs)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_op(input logic v, input logic [7:0] cs, input logic [15:0] addr,
                            input logic [15:0] alu, input logic [15:0] st);
        mem_v          = v;
        mem_cs         = cs;
        mem_address    = addr;
        mem_alu_result = alu;
        mem_st_data    = st;
    endtask

    task automatic drive_mem(input logic rdy, input logic [15:0] rd);
        dmem_ready = rdy;
        dmem_rdata = rd;
    endtask

    // Move to mid-cycle for combinational checks.
    task automatic mid;
        #3;
    endtask

    // Advance through the next rising edge and settle.
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        mem_ir = 16'h0000; mem_npc = 16'h0000; mem_drid = 3'd0;
        drive_op(1'b0, 8'h00, 16'h0000, 16'h0000, 16'h0000);
        drive_mem(1'b0, 16'h0000);
        step(); step();
        check("rst_sr_v", {15'd0, sr_v}, 16'h0000);
        check("rst_sr_data", sr_data, 16'h0000);
        check("rst_sr_alu", sr_alu_result, 16'h0000);
        // Outputs must stay quiet under reset even with a load presented.
        drive_op(1'b1, 8'h10, 16'h1234, 16'h0000, 16'h0000);
        mid();
        check("rst_req", {15'd0, dmem_req}, 16'h0000);
        check("rst_stall", {15'd0, mem_stall}, 16'h0000);
        step();
        reset = 1'b0;

        // ADD-type op: no access, passes through in one cycle.
        drive_op(1'b1, 8'h0B, 16'h0042, 16'hBEEF, 16'h0000);
        mem_ir = 16'h1A2B; mem_npc = 16'h3002; mem_drid = 3'd5;
        mid();
        check("add_stall", {15'd0, mem_stall}, 16'h0000);
        check("add_req", {15'd0, dmem_req}, 16'h0000);
        step();
        check("add_sr_v", {15'd0, sr_v}, 16'h0001);
        check("add_sr_alu", sr_alu_result, 16'hBEEF);
        check("add_sr_data", sr_data, 16'h0000);
        check("add_sr_cs", {12'd0, sr_cs}, 16'h000B);
        check("add_sr_ir", sr_ir, 16'h1A2B);
        check("add_sr_npc", sr_npc, 16'h3002);
        check("add_sr_addr", sr_address, 16'h0042);
        check("add_sr_drid", {13'd0, sr_drid}, 16'h0005);

        // LDW with two wait cycles.
        drive_op(1'b1, 8'h10, 16'h1234, 16'h0000, 16'h0000);
        mem_drid = 3'd2;
        drive_mem(1'b0, 16'h0000);
        stall_cnt = 0;
        mid();
        check("ldw_req", {15'd0, dmem_req}, 16'h0001);
        check("ldw_we", {15'd0, dmem_we}, 16'h0000);
        check("ldw_addr", dmem_addr, 16'h1234);
        check("ldw_mask", {14'd0, dmem_wmask}, 16'h0003);
        if (mem_stall) stall_cnt++;
        step();
        check("ldw_bubble1", {15'd0, sr_v}, 16'h0000);
        check("ldw_hold_alu", sr_alu_result, 16'hBEEF);
        mid();
        if (mem_stall) stall_cnt++;
        step();
        check("ldw_bubble2", {15'd0, sr_v}, 16'h0000);
        drive_mem(1'b1, 16'hCAFE);
        mid();
        if (mem_stall) stall_cnt++;
        check("ldw_req_held", {15'd0, dmem_req}, 16'h0001);
        step();
        check("ldw_stall_cycles", stall_cnt[15:0], 16'd2);
        check("ldw_sr_v", {15'd0, sr_v}, 16'h0001);
        check("ldw_sr_data", sr_data, 16'hCAFE);

        // LDB odd address: high byte, sign-extended.
        drive_op(1'b1, 8'h50, 16'h3001, 16'h0000, 16'h0000);
        drive_mem(1'b1, 16'h80FF);
        mid();
        check("ldb_odd_mask", {14'd0, dmem_wmask}, 16'h0002);
        check("ldb_odd_addr", dmem_addr, 16'h3001);
        check("ldb_odd_stall", {15'd0, mem_stall}, 16'h0000);
        step();
        check("ldb_odd_data", sr_data, 16'hFF80);

        // LDB even address: low byte, positive.
        drive_op(1'b1, 8'h50, 16'h3002, 16'h0000, 16'h0000);
        drive_mem(1'b1, 16'h1234);
        mid();
        check("ldb_even_mask", {14'd0, dmem_wmask}, 16'h0001);
        step();
        check("ldb_even_data", sr_data, 16'h0034);

        // STB even address.
        drive_op(1'b1, 8'h60, 16'h3000, 16'h0000, 16'h12AB);
        drive_mem(1'b1, 16'hFFFF);
        mid();
        check("stb_we", {15'd0, dmem_we}, 16'h0001);
        check("stb_mask", {14'd0, dmem_wmask}, 16'h0001);
        check("stb_wdata", dmem_wdata, 16'hABAB);
        step();
        check("stb_sr_v", {15'd0, sr_v}, 16'h0001);
        check("stb_sr_data", sr_data, 16'h0000);

        // STI: read pointer at 4000, then write at 5000.
        drive_op(1'b1, 8'hA0, 16'h4000, 16'h0000, 16'h7777);
        drive_mem(1'b1, 16'h5000);
        mid();
        check("sti_rd_addr", dmem_addr, 16'h4000);
        check("sti_rd_we", {15'd0, dmem_we}, 16'h0000);
        check("sti_stall1", {15'd0, mem_stall}, 16'h0001);
        step();
        check("sti_bubble", {15'd0, sr_v}, 16'h0000);
        drive_mem(1'b1, 16'h0000);
        mid();
        check("sti_wr_addr", dmem_addr, 16'h5000);
        check("sti_wr_we", {15'd0, dmem_we}, 16'h0001);
        check("sti_wr_data", dmem_wdata, 16'h7777);
        check("sti_wr_mask", {14'd0, dmem_wmask}, 16'h0003);
        check("sti_stall2", {15'd0, mem_stall}, 16'h0000);
        step();
        check("sti_sr_v", {15'd0, sr_v}, 16'h0001);

        // LDW at an odd address.
        drive_op(1'b1, 8'h10, 16'h0101, 16'h0000, 16'h0000);
        drive_mem(1'b1, 16'hAAAA);
        mid();
`ifdef MEM_UNALIGNED_TRAP_EN
        check("unal_flag", {15'd0, mem_unaligned}, 16'h0001);
        check("unal_req", {15'd0, dmem_req}, 16'h0000);
        check("unal_stall", {15'd0, mem_stall}, 16'h0000);
        step();
        check("unal_sr_v", {15'd0, sr_v}, 16'h0000);
        drive_op(1'b0, 8'h00, 16'h0000, 16'h0000, 16'h0000);
        mid();
        check("unal_pulse_end", {15'd0, mem_unaligned}, 16'h0000);
        step();
`else
        check("unal_addr", dmem_addr, 16'h0100);
        check("unal_flag", {15'd0, mem_unaligned}, 16'h0000);
        step();
        check("unal_sr_data", sr_data, 16'hAAAA);
`endif

        // Reset while waiting abandons the access.
        drive_op(1'b1, 8'h10, 16'h2000, 16'h0000, 16'h0000);
        drive_mem(1'b0, 16'h0000);
        step();
        reset = 1'b1;
        mid();
        check("rstw_req", {15'd0, dmem_req}, 16'h0000);
        step();
        check("rstw_sr_v", {15'd0, sr_v}, 16'h0000);
        reset = 1'b0;
        drive_op(1'b0, 8'h10, 16'h2000, 16'h0000, 16'h0000);
        mid();
        check("rstw_idle_req", {15'd0, dmem_req}, 16'h0000);
        check("rstw_idle_stall", {15'd0, mem_stall}, 16'h0000);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory (MEM) stage of the LC-3b pipeline, sitting between the address-generate/execute latch and the SR stage. It performs the instruction's data-memory access (word/byte load/store, one-level indirect LDI/STI) over a ready-based handshake and stalls upstream while the access is outstanding. It registers the SR-stage latch (`sr_v`, `sr_ir`, `sr_npc`, `sr_address`, `sr_alu_result`, `sr_data`, `sr_drid`, `sr_cs`).

## Interface
- No parameters. Data width fixed at 16 bits.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high reset.
- `mem_v` in 1: instruction in MEM latch is valid.
- `mem_ir`, `mem_npc`, `mem_address`, `mem_alu_result` in 16 each: passed to the SR latch. `mem_address` is also the first access address.
- `mem_st_data` in 16: store source value.
- `mem_drid` in 3: destination register ID.
- `mem_cs` in 8: `[3:0]` SR control, passed through; `[4]` rd; `[5]` wr; `[6]` byte; `[7]` indirect.
- `mem_stall` out 1: hold the upstream latch this cycle.
- `mem_unaligned` out 1: one-cycle flag for a word access at an odd address.
- `dmem_req`, `dmem_we` out 1 each: access request and write enable.
- `dmem_addr`, `dmem_wdata` out 16 each: access address and write data.
- `dmem_wmask` out 2: byte-lane enables, `[1]` high byte.
- `dmem_rdata` in 16: read data, valid when `dmem_ready` is high.
- `dmem_ready` in 1: access completes this cycle.
- `sr_v` out 1, `sr_ir`, `sr_npc`, `sr_address`, `sr_alu_result`, `sr_data` out 16 each, `sr_drid` out 3, `sr_cs` out 4: registered SR latch.

## Operation
- A memory op is `mem_v & (rd | wr)`. If `wr` is set, the final access writes and `rd` is ignored. If `indirect` is set, `byte` is ignored and all accesses are word accesses.
- FSM states:
  - IDLE: first access at `mem_address`.
    - `dmem_ready` low: go to WAIT1.
    - `dmem_ready` high and indirect: capture `ptr <= dmem_rdata`, go to ACC2.
    - `dmem_ready` high, not indirect: complete.
  - WAIT1: same request held; same exits as IDLE.
  - ACC2: access at `ptr` with the final direction; `dmem_ready` high means complete, go to IDLE.
- Request signals (combinational from state and inputs):
  - `dmem_req` is high in IDLE for a memory op, and always high in WAIT1 and ACC2.
  - `dmem_we` is high only on the final access of a `wr` op. The indirect first access is always a read.
- Byte access (A = access address):
  - `dmem_addr = A`, `dmem_wmask = A[0] ? 2'b10 : 2'b01`, `dmem_wdata = {st[7:0], st[7:0]}`.
  - Load result is the selected byte, sign-extended.
- Word access: `dmem_wmask = 2'b11`, `dmem_wdata = mem_st_data`, load result = `dmem_rdata`.
- SR latch update, every cycle unless reset:
  - On completion or non-memory cycle: `sr_v <= mem_v`, all other fields copied from `mem_*`, `sr_cs <= mem_cs[3:0]`.
  - `sr_data <=` load result for reads, `16'h0000` for stores and non-memory ops.
  - While stalled: `sr_v <= 0` (bubble); other `sr_*` hold.
- `mem_stall` = memory op present and not completing this cycle.

## Timing
- Reset values: `sr_*` = 0, `sr_v` = 0, state = IDLE, `ptr` = 0.
  - `dmem_req`, `dmem_we`, `mem_stall`, `mem_unaligned` are forced to 0 while `reset` is high.
- Reset mid-access abandons the operation. No retry; IDLE on the next cycle.
- Latency:
  - Non-memory op: 1 cycle to the SR latch.
  - Zero-wait access (`dmem_ready` in the same cycle as the request): 1 cycle, no stall.
  - Each low-ready cycle adds 1 stall cycle.
  - Indirect with zero-wait memory: 2 cycles, 1 stall.
- Upstream holds all `mem_*` inputs stable while `mem_stall` is high. The memory slave samples `dmem_*` only when `dmem_req & dmem_ready`.
- `mem_v` = 0 in IDLE: no request, bubble passed through.

## Configuration
- `MEM_UNALIGNED_TRAP_EN`:
  - Defined: a non-byte access with `A[0] = 1` issues no request and pulses `mem_unaligned` for one cycle. The instruction is dropped: `sr_v <= 0`, no stall.
    - For the indirect second access, detection happens in ACC2, which then returns to IDLE.
  - Undefined: `dmem_addr[0]` is forced to 0 on word accesses and `mem_unaligned` is tied to 0.

## Test plan
- ADD-type op: `mem_cs = 8'h0B`, `mem_alu_result = 16'hBEEF`, no access. Next edge: `sr_v = 1`, `sr_alu_result = BEEF`, `sr_data = 0`, `mem_stall` never high.
- LDW to `16'h1234`, `dmem_ready` low for 2 cycles then high with rdata `16'hCAFE`. Required: `mem_stall` high for exactly 2 cycles; `sr_v = 0` during those cycles; then `sr_data = CAFE`.
- LDB to `16'h3001`, rdata `16'h80FF`. Required: `dmem_wmask = 10`, `sr_data = 16'hFF80`.
- STB to `16'h3000` with st `16'h12AB`. Required: `dmem_we = 1`, `wmask = 01`, `wdata = 16'hABAB`.
- STI at `16'h4000`, zero-wait memory, first read returns `16'h5000`. Required: read at 4000, then write of `mem_st_data` at 5000 the next cycle; exactly 1 stall cycle.
- LDW to `16'h0101`:
  - With `MEM_UNALIGNED_TRAP_EN`: `mem_unaligned` pulses, `dmem_req = 0`, `sr_v = 0`.
  - Without: `dmem_addr = 0100`.
- Also: assert `reset` during WAIT1. Required: `dmem_req` low and `sr_v = 0` on the next edge, then IDLE.
